yacht_score_eval: RTL and testbench

- Sequential scoring engine sitting directly downstream of the dice manager.
- On an eval_start pulse it snapshots the five dice values (1~6), builds a face histogram one die per cycle, then scores the 12 Yacht categories one per cycle into an internal score table.
- The game FSM and display logic read the table through a category index.
- Used to show the potential score of every category before the player commits one.

---
 rtl/yacht_score_eval.sv | 200 ++++++++++++++++++++
 tb/tb_yacht_score_eval.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/yacht_score_eval.sv
// Sequential Yacht scorer: snapshots five dice, builds a face histogram,
// then fills a 12-entry score table. Optional best tracker: YACHT_SCORE_BEST_EN.
module yacht_score_eval #(
  parameter int unsigned SS_PTS    = 15,
  parameter int unsigned LS_PTS    = 30,
  parameter int unsigned YACHT_PTS = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       eval_start,
  input  logic [2:0] dice1,
  input  logic [2:0] dice2,
  input  logic [2:0] dice3,
  input  logic [2:0] dice4,
  input  logic [2:0] dice5,
  input  logic [3:0] cat_sel,
  output logic       busy,
  output logic       done,
  output logic       invalid,
  output logic [5:0] score_out,
  output logic [3:0] best_cat,
  output logic [5:0] best_score
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EVAL,
    FIN
  } state_t;

  state_t     state_q;
  logic [2:0] snap_q [5];
  logic [2:0] hist_q [1:6];
  logic [4:0] sum_q;
  logic       err_q;
  logic [3:0] idx_q;
  logic [5:0] tbl_q  [12];

  logic [2:0] cur_die;
  logic       die_bad;
  logic [6:1] pres;
  logic       any4;
  logic       any5;
  logic       has3;
  logic       has2;
  logic       ss;
  logic       ls;
  logic [5:0] sum6;
  logic [5:0] face_val;
  logic [5:0] cat_val;

  assign cur_die = snap_q[0];
  assign die_bad = (cur_die == 3'd0) || (cur_die == 3'd7);
  assign sum6    = {1'b0, sum_q};

  always_comb begin
    any4     = 1'b0;
    any5     = 1'b0;
    has3     = 1'b0;
    has2     = 1'b0;
    pres     = '0;
    face_val = '0;
    for (int f = 1; f <= 6; f++) begin
      pres[f] = (hist_q[f] != 3'd0);
      any4    = any4 | (hist_q[f] >= 3'd4);
      any5    = any5 | (hist_q[f] == 3'd5);
      has3    = has3 | (hist_q[f] == 3'd3);
      has2    = has2 | (hist_q[f] == 3'd2);
      if (idx_q == 4'(f - 1))
        face_val = 6'(hist_q[f]) * 6'(f);
    end
    ss = (&pres[4:1]) | (&pres[5:2]) | (&pres[6:3]);
    ls = (&pres[5:1]) | (&pres[6:2]);
  end

  // Five of a kind has no 3 or 2 bin, so it never scores as a full house.
  always_comb begin
    cat_val = '0;
    case (idx_q)
      4'd6:    cat_val = sum6;
      4'd7:    cat_val = any4 ? sum6 : 6'd0;
      4'd8:    cat_val = (has3 && has2) ? sum6 : 6'd0;
      4'd9:    cat_val = ss ? 6'(SS_PTS) : 6'd0;
      4'd10:   cat_val = ls ? 6'(LS_PTS) : 6'd0;
      4'd11:   cat_val = any5 ? 6'(YACHT_PTS) : 6'd0;
      default: cat_val = face_val;
    endcase
    if (err_q)
      cat_val = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      for (int i = 0; i < 5; i++) snap_q[i] <= '0;
      for (int f = 1; f <= 6; f++) hist_q[f] <= '0;
      for (int c = 0; c < 12; c++) tbl_q[c] <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (eval_start) begin
            snap_q[0] <= dice1;
            snap_q[1] <= dice2;
            snap_q[2] <= dice3;
            snap_q[3] <= dice4;
            snap_q[4] <= dice5;
            for (int f = 1; f <= 6; f++) hist_q[f] <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (die_bad) begin
            err_q <= 1'b1;
          end else begin
            for (int f = 1; f <= 6; f++)
              if (cur_die == 3'(f))
                hist_q[f] <= hist_q[f] + 3'd1;
            sum_q <= sum_q + {2'b00, cur_die};
          end
          for (int i = 0; i < 4; i++) snap_q[i] <= snap_q[i+1];
          snap_q[4] <= '0;
          if (idx_q == 4'd4) begin
            idx_q   <= '0;
            state_q <= EVAL;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        EVAL: begin
          for (int c = 0; c < 12; c++)
            if (idx_q == 4'(c))
              tbl_q[c] <= cat_val;
          if (idx_q == 4'd11) begin
            idx_q   <= '0;
            state_q <= FIN;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          invalid <= err_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    score_out = '0;
    for (int c = 0; c < 12; c++)
      if (cat_sel == 4'(c))
        score_out = tbl_q[c];
  end

`ifdef YACHT_SCORE_BEST_EN
  logic [3:0] run_cat_q;
  logic [5:0] run_score_q;

  // Strictly-greater update keeps the lowest index on ties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cat_q   <= '0;
      run_score_q <= '0;
      best_cat    <= '0;
      best_score  <= '0;
    end else begin
      if (state_q == IDLE && eval_start) begin
        run_cat_q   <= '0;
        run_score_q <= '0;
      end else if (state_q == EVAL && cat_val > run_score_q) begin
        run_cat_q   <= idx_q;
        run_score_q <= cat_val;
      end
      if (state_q == FIN) begin
        best_cat   <= run_cat_q;
        best_score <= run_score_q;
      end
    end
  end
`else
  assign best_cat   = '0;
  assign best_score = '0;
`endif

endmodule

// File: tb/tb_yacht_score_eval.sv
// Directed bench for yacht_score_eval: vector table plus
// busy-retrigger and mid-run reset sequences.
module tb_yacht_score_eval;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       eval_start = 1'b0;
  logic [2:0] dice1 = '0;
  logic [2:0] dice2 = '0;
  logic [2:0] dice3 = '0;
  logic [2:0] dice4 = '0;
  logic [2:0] dice5 = '0;
  logic [3:0] cat_sel = '0;
  logic       busy;
  logic       done;
  logic       invalid;
  logic [5:0] score_out;
  logic [3:0] best_cat;
  logic [5:0] best_score;

  int checks = 0;
  int errors = 0;

  yacht_score_eval dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .eval_start(eval_start),
    .dice1     (dice1),
    .dice2     (dice2),
    .dice3     (dice3),
    .dice4     (dice4),
    .dice5     (dice5),
    .cat_sel   (cat_sel),
    .busy      (busy),
    .done      (done),
    .invalid   (invalid),
    .score_out (score_out),
    .best_cat  (best_cat),
    .best_score(best_score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0]      dice;
    logic [0:11][5:0] e;
    logic             inv;
    logic [3:0]       bc;
    logic [5:0]       bs;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mkv(input logic [14:0] d, input logic [71:0] e,
                               input logic inv, input logic [3:0] bc,
                               input logic [5:0] bs);
    vec_t v;
    v.dice = d;
    v.e    = e;
    v.inv  = inv;
    v.bc   = bc;
    v.bs   = bs;
    return v;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic set_dice(input logic [14:0] d);
    {dice1, dice2, dice3, dice4, dice5} = d;
  endtask

  task automatic start_eval(input logic [14:0] d);
    @(negedge clk);
    set_dice(d);
    eval_start = 1'b1;
    @(posedge clk);
    #1;
    eval_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_table(input string tag, input vec_t v);
    for (int c = 0; c < 12; c++) begin
      cat_sel = 4'(c);
      #1;
      chk($sformatf("%s cat%0d", tag, c), int'(score_out), int'(v.e[c]));
    end
  endtask

  task automatic check_best(input string tag, input vec_t v);
    int ebc;
    int ebs;
`ifdef YACHT_SCORE_BEST_EN
    ebc = int'(v.bc);
    ebs = int'(v.bs);
`else
    ebc = 0;
    ebs = 0;
`endif
    chk({tag, " best_cat"}, int'(best_cat), ebc);
    chk({tag, " best_score"}, int'(best_score), ebs);
  endtask

  initial begin
    int lat;
    int ndone;
    int first;

    vecs[0] = mkv({3'd3,3'd3,3'd3,3'd5,3'd5},
      {6'd0,6'd0,6'd9,6'd0,6'd10,6'd0,6'd19,6'd0,6'd19,6'd0,6'd0,6'd0},
      1'b0, 4'd6, 6'd19);
    vecs[1] = mkv({3'd6,3'd6,3'd6,3'd6,3'd6},
      {6'd0,6'd0,6'd0,6'd0,6'd0,6'd30,6'd30,6'd30,6'd0,6'd0,6'd0,6'd50},
      1'b0, 4'd11, 6'd50);
    vecs[2] = mkv({3'd1,3'd2,3'd3,3'd4,3'd6},
      {6'd1,6'd2,6'd3,6'd4,6'd0,6'd6,6'd16,6'd0,6'd0,6'd15,6'd0,6'd0},
      1'b0, 4'd6, 6'd16);
    vecs[3] = mkv({3'd2,3'd3,3'd4,3'd5,3'd6},
      {6'd0,6'd2,6'd3,6'd4,6'd5,6'd6,6'd20,6'd0,6'd0,6'd15,6'd30,6'd0},
      1'b0, 4'd10, 6'd30);
    vecs[4] = mkv({3'd0,3'd0,3'd0,3'd0,3'd0}, 72'd0, 1'b1, 4'd0, 6'd0);
    vecs[5] = mkv({3'd4,3'd4,3'd4,3'd4,3'd1},
      {6'd1,6'd0,6'd0,6'd16,6'd0,6'd0,6'd17,6'd17,6'd0,6'd0,6'd0,6'd0},
      1'b0, 4'd6, 6'd17);
    vecs[6] = mkv({3'd1,3'd1,3'd2,3'd2,3'd2},
      {6'd2,6'd6,6'd0,6'd0,6'd0,6'd0,6'd8,6'd0,6'd8,6'd0,6'd0,6'd0},
      1'b0, 4'd6, 6'd8);
    vecs[7] = mkv({3'd1,3'd2,3'd3,3'd4,3'd5},
      {6'd1,6'd2,6'd3,6'd4,6'd5,6'd0,6'd15,6'd0,6'd0,6'd15,6'd30,6'd0},
      1'b0, 4'd10, 6'd30);
    vecs[8] = mkv({3'd5,3'd5,3'd7,3'd5,3'd5}, 72'd0, 1'b1, 4'd0, 6'd0);
    vecs[9] = vecs[0];

    #12;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset invalid", int'(invalid), 0);
    chk("reset score", int'(score_out), 0);
    chk("reset best_cat", int'(best_cat), 0);
    chk("reset best_score", int'(best_score), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      start_eval(vecs[v].dice);
      chk($sformatf("v%0d busy", v), int'(busy), 1);
      wait_done(lat);
      chk($sformatf("v%0d latency", v), lat, 18);
      chk($sformatf("v%0d busy@done", v), int'(busy), 0);
      chk($sformatf("v%0d invalid", v), int'(invalid), int'(vecs[v].inv));
      check_best($sformatf("v%0d", v), vecs[v]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done pulse", v), int'(done), 0);
      check_table($sformatf("v%0d", v), vecs[v]);
    end

    for (int c = 12; c < 16; c++) begin
      cat_sel = 4'(c);
      #1;
      chk($sformatf("sel%0d zero", c), int'(score_out), 0);
    end

    // Retrigger while busy and change dice mid-run.
    start_eval(vecs[1].dice);
    repeat (4) @(posedge clk);
    @(negedge clk);
    set_dice({3'd1,3'd2,3'd3,3'd4,3'd5});
    eval_start = 1'b1;
    @(posedge clk);
    #1;
    eval_start = 1'b0;
    set_dice({3'd2,3'd2,3'd2,3'd2,3'd2});
    ndone = 0;
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first < 0) first = k;
      end
    end
    chk("retrig done count", ndone, 1);
    chk("retrig latency", first + 5, 18);
    check_best("retrig", vecs[1]);
    check_table("retrig", vecs[1]);

    // Invalid run, then reset partway through the next one.
    start_eval(vecs[4].dice);
    wait_done(lat);
    chk("pre-reset invalid", int'(invalid), 1);
    start_eval(vecs[0].dice);
    repeat (9) @(posedge clk);
    #1;
    chk("pre-reset busy", int'(busy), 1);
    cat_sel = 4'd2;
    #1;
    chk("pre-reset partial cat2", int'(score_out), 9);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid-reset busy", int'(busy), 0);
    chk("mid-reset done", int'(done), 0);
    chk("mid-reset invalid", int'(invalid), 0);
    check_table("mid-reset", vecs[4]);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("post-reset no done", ndone, 0);
    chk("post-reset busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
